vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
- Parametrised successor to the fixed 20-cent penny/nickel/dime vending FSM.
- Coin values and price are parameters instead of hard-coded states.
- Adds active change dispensing (coin-return pulses, largest coin first), cancel/refund and a vend hold time.
- Sits after the synchroniser/debouncer/edge-detector chain, so all command inputs are single-cycle ticks.
- Drives the BCD/segment display path through `credit` and `change`.

Parameters:
- PRICE, 20: product price in cents; must be at least 1.
- CREDIT_W, 6: width of the credit and change registers; must satisfy 2^CREDIT_W > PRICE + D_VAL - 1.
- P_VAL, 1: value of coin input `p`.
- N_VAL, 5: value of coin input `n`.
- D_VAL, 10: value of coin input `d`; must satisfy D_VAL > N_VAL > P_VAL = 1.
- VEND_HOLD, 4: number of cycles `vend` stays high.
- TIMEOUT_S, 30: `sec_tick` count with no coin before auto-refund (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- p  in  1  penny tick, one cycle.
- n  in  1  nickel tick, one cycle.
- d  in  1  dime tick, one cycle.
- s  in  1  cancel tick, one cycle.
- sec_tick  in  1  one-cycle pulse once per second.
- credit  out  CREDIT_W  credit accumulated so far.
- change  out  CREDIT_W  change or refund still to be returned.
- vend  out  1  product release.
- ret_p  out  1  return-one-penny pulse.
- ret_n  out  1  return-one-nickel pulse.
- ret_d  out  1  return-one-dime pulse.
- coin_rej  out  1  pulse: a coin arrived while busy or was dropped.
- busy  out  1  high in VEND, CHANGE and REFUND.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; credit = 0, change = 0, timeout counter = 0; every output is 0.
- Outputs are registered. Coin-accept latency is 1 cycle: the tick in cycle t updates `credit` at t+1.
- States: IDLE, ACCUM, VEND, CHANGE, REFUND.
- Coin priority is p > n > d. At most one coin is credited per cycle; any other coin ticks in that cycle are dropped and `coin_rej` pulses.
- IDLE / ACCUM:
  - A coin adds its value to `credit`; the state becomes ACCUM.
  - If the new credit is >= PRICE: go to VEND; `change` is loaded with credit - PRICE; `credit` holds its value.
  - `s` with credit > 0: go to REFUND with `change` = credit and `credit` = 0.
  - `s` with credit = 0: ignored.
  - A coin and `s` in the same cycle: the coin is credited first. If the result is below PRICE, the refund uses the new credit. If it reaches PRICE, vend wins and `s` is dropped.
- VEND:
  - `vend` = 1 for exactly VEND_HOLD cycles, then go to CHANGE.
  - `credit` clears to 0 when VEND is left.
  - `s` is ignored.
- CHANGE / REFUND (identical datapath):
  - Each cycle, while `change` > 0, emit exactly one return pulse for the largest coin not exceeding `change`: `ret_d` if change >= D_VAL, else `ret_n` if change >= N_VAL, else `ret_p`.
  - `change` decreases by that coin's value on the same edge.
  - When `change` = 0, go to IDLE in that cycle. CHANGE with initial change 0 lasts exactly 1 cycle and emits no pulse.
- Busy rules: coins arriving in VEND, CHANGE or REFUND are not credited and `coin_rej` pulses (one cycle per offending tick cycle). `busy` = 1 in those states.
- Width: credit never exceeds PRICE + D_VAL - 1, so no wrap. Arithmetic is unsigned CREDIT_W.
- Reset mid-dispense: everything clears; the pending change is lost.

Optional Feature:
- VEND_TIMEOUT_EN defined:
  - In ACCUM, a counter increments on each `sec_tick` and clears on any accepted coin.
  - On reaching TIMEOUT_S, go to REFUND with `change` = credit, `credit` = 0, counter = 0.
  - A timeout in the same cycle as a coin is cancelled by the coin.
- Not defined: no counter logic; credit is held indefinitely; `sec_tick` is unused.

Test Plan:
- Hold rst low for 3 cycles mid-ACCUM (credit 7) -> credit = 0, change = 0, vend = 0, busy = 0 immediately, with no clk edge needed.
- d, d (defaults) -> credit 10 then 20; vend high 4 cycles; then CHANGE for 1 cycle with no ret pulses; IDLE with credit 0.
- d, n, p, p, p, p (credit 19), then d -> credit 29, vend for 4 cycles, change 9, then ret_n once followed by ret_p four times on consecutive cycles, change 9→4→3→2→1→0; IDLE after 5 dispense cycles.
- d, n, then s -> REFUND with change 15, ret_d then ret_n, credit 0; `s` with credit 0 -> no state change.
- p and d in the same cycle -> credit +1 only, coin_rej = 1. A dime during VEND -> coin_rej pulse, credit unchanged.
- With VEND_TIMEOUT_EN: n, p (credit 6), then 30 sec_ticks with no coin -> REFUND with ret_n, ret_p. A coin at tick 29 -> counter resets and no refund.

Source files
------------

// File: rtl/vend_controller.sv
// Parametrised vending controller: coin accumulation, timed vend, largest-coin-first change and refund.
// Optional auto-refund on inactivity is compiled in when VEND_TIMEOUT_EN is defined.
module vend_controller #(
  parameter int PRICE     = 20,
  parameter int CREDIT_W  = 6,
  parameter int P_VAL     = 1,
  parameter int N_VAL     = 5,
  parameter int D_VAL     = 10,
  parameter int VEND_HOLD = 4,
  parameter int TIMEOUT_S = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p,
  input  logic                n,
  input  logic                d,
  input  logic                s,
  input  logic                sec_tick,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                vend,
  output logic                ret_p,
  output logic                ret_n,
  output logic                ret_d,
  output logic                coin_rej,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] P_C     = CREDIT_W'(P_VAL);
  localparam logic [CREDIT_W-1:0] N_C     = CREDIT_W'(N_VAL);
  localparam logic [CREDIT_W-1:0] D_C     = CREDIT_W'(D_VAL);
  localparam int                  HOLD_W  = (VEND_HOLD > 1) ? $clog2(VEND_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(VEND_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_VEND,
    S_CHANGE,
    S_REFUND
  } state_t;

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CREDIT_W-1:0]   change_q, change_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  vend_q, vend_d;
  logic                  ret_p_q, ret_p_d;
  logic                  ret_n_q, ret_n_d;
  logic                  ret_d_q, ret_d_d;
  logic                  rej_q, rej_d;
  logic                  busy_q, busy_d;

  logic                  coin_any;
  logic                  coin_multi;
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W-1:0]   coin_sum;

`ifdef VEND_TIMEOUT_EN
  localparam int               TMO_W    = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_S - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_sec_tick;
  assign unused_sec_tick = sec_tick;
`endif

  // Priority p > n > d: only the highest-priority tick is credited.
  assign coin_any   = p | n | d;
  assign coin_multi = (p & n) | (p & d) | (n & d);
  assign coin_val   = p ? P_C : (n ? N_C : (d ? D_C : '0));
  assign coin_sum   = credit_q + coin_val;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    hold_d   = hold_q;
    ret_p_d  = 1'b0;
    ret_n_d  = 1'b0;
    ret_d_d  = 1'b0;
    rej_d    = 1'b0;
`ifdef VEND_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    case (state_q)
      S_IDLE, S_ACCUM: begin
        rej_d = coin_multi;
        if (coin_any) begin
`ifdef VEND_TIMEOUT_EN
          tmo_d = '0;
`endif
          credit_d = coin_sum;
          if (coin_sum >= PRICE_C) begin
            state_d  = S_VEND;
            change_d = coin_sum - PRICE_C;
            hold_d   = '0;
          end else if (s) begin
            state_d  = S_REFUND;
            change_d = coin_sum;
            credit_d = '0;
          end else begin
            state_d = S_ACCUM;
          end
        end else if (s && credit_q != '0) begin
          state_d  = S_REFUND;
          change_d = credit_q;
          credit_d = '0;
        end
`ifdef VEND_TIMEOUT_EN
        else if (state_q == S_ACCUM && sec_tick) begin
          if (tmo_q == TMO_LAST) begin
            state_d  = S_REFUND;
            change_d = credit_q;
            credit_d = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
`endif
      end

      S_VEND: begin
        rej_d = coin_any;
        if (hold_q == HOLD_LAST) begin
          state_d  = S_CHANGE;
          credit_d = '0;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      S_CHANGE, S_REFUND: begin
        rej_d = coin_any;
        if (change_q == '0) begin
          state_d = S_IDLE;
        end else begin
          if (change_q >= D_C) begin
            ret_d_d  = 1'b1;
            change_d = change_q - D_C;
          end else if (change_q >= N_C) begin
            ret_n_d  = 1'b1;
            change_d = change_q - N_C;
          end else begin
            ret_p_d  = 1'b1;
            change_d = change_q - P_C;
          end
          // Leave on the edge that returns the last coin rather than idling a cycle at zero.
          if (change_d == '0) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        change_d = '0;
        hold_d   = '0;
      end
    endcase

`ifdef VEND_TIMEOUT_EN
    if (state_d != S_ACCUM) begin
      tmo_d = '0;
    end
`endif

    vend_d = (state_d == S_VEND);
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE) || (state_d == S_REFUND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      change_q <= '0;
      hold_q   <= '0;
      vend_q   <= 1'b0;
      ret_p_q  <= 1'b0;
      ret_n_q  <= 1'b0;
      ret_d_q  <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      hold_q   <= hold_d;
      vend_q   <= vend_d;
      ret_p_q  <= ret_p_d;
      ret_n_q  <= ret_n_d;
      ret_d_q  <= ret_d_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign credit   = credit_q;
  assign change   = change_q;
  assign vend     = vend_q;
  assign ret_p    = ret_p_q;
  assign ret_n    = ret_n_q;
  assign ret_d    = ret_d_q;
  assign coin_rej = rej_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: return pulses are scoreboarded against a queue filled
// when the purchase/refund is stimulated; state and credit checks are inline in each scenario task.
module tb_vend_controller;

  localparam int CW = 6;

  logic          clk;
  logic          rst;
  logic          p, n, d, s, sec_tick;
  logic [CW-1:0] credit, change;
  logic          vend, ret_p, ret_n, ret_d, coin_rej, busy;

  typedef struct {
    logic [2:0]    coin;  // {d, n, p}
    logic [CW-1:0] chg;   // change remaining after the pulse
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  vend_controller dut (
    .clk      (clk),
    .rst      (rst),
    .p        (p),
    .n        (n),
    .d        (d),
    .s        (s),
    .sec_tick (sec_tick),
    .credit   (credit),
    .change   (change),
    .vend     (vend),
    .ret_p    (ret_p),
    .ret_n    (ret_n),
    .ret_d    (ret_d),
    .coin_rej (coin_rej),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 ns after a rising edge; returns 1 ns after the edge that samples the ticks.
  task automatic drive(input logic ip, input logic in, input logic id, input logic is, input logic ist);
    p = ip; n = in; d = id; s = is; sec_tick = ist;
    @(posedge clk); #1;
    p = 1'b0; n = 1'b0; d = 1'b0; s = 1'b0; sec_tick = 1'b0;
    $display("[%0t] in p%b n%b d%b s%b t%b -> credit=%0d change=%0d busy=%b rej=%b",
             $time, ip, in, id, is, ist, credit, change, busy, coin_rej);
  endtask

  task automatic push_ret(input logic [2:0] coin, input int chg);
    exp_t e;
    e.coin = coin;
    e.chg  = CW'(chg);
    sb_q.push_back(e);
  endtask

  task automatic wait_vend(input string tag, input int exp_cycles);
    int cnt = 0;
    while (vend === 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cnt !== exp_cycles) begin
      n_bad++;
      $display("FAIL %s vend_cycles: got %0d expected %0d", tag, cnt, exp_cycles);
    end
  endtask

  task automatic wait_dispense(input string tag, input int exp_cycles);
    int         cyc = 0;
    logic [2:0] r;
    exp_t       e;
    do begin
      @(posedge clk); #1;
      cyc++;
      r = {ret_d, ret_n, ret_p};
      if (r !== 3'b000) begin
        $display("[%0t] %s ret dnp=%b change=%0d", $time, tag, r, change);
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s unexpected_ret: got %b expected none", tag, r);
        end else begin
          e = sb_q.pop_front();
          if (r !== e.coin || change !== e.chg) begin
            n_bad++;
            $display("FAIL %s ret: got dnp=%b change=%0d expected dnp=%b change=%0d",
                     tag, r, change, e.coin, e.chg);
          end
        end
      end
    end while (busy === 1'b1 && cyc < 60);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s dispense_timeout: got busy=%b expected 0", tag, busy);
    end
    if (exp_cycles >= 0) begin
      n_cmp++;
      if (cyc !== exp_cycles) begin
        n_bad++;
        $display("FAIL %s dispense_cycles: got %0d expected %0d", tag, cyc, exp_cycles);
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s missing_ret: got %0d pending expected 0", tag, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({credit, change, vend, ret_p, ret_n, ret_d, coin_rej, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_init: got credit=%0d change=%0d vend=%b busy=%b expected all 0",
               credit, change, vend, busy);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    n_cmp++;
    if (credit !== 6'd7) begin
      n_bad++;
      $display("FAIL reset_pre_credit: got %0d expected 7", credit);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (credit !== 6'd0 || change !== 6'd0 || vend !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: got credit=%0d change=%0d vend=%b busy=%b expected 0",
               credit, change, vend, busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (credit !== 6'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got credit=%0d busy=%b expected 0/0", credit, busy);
    end
  endtask

  task automatic test_exact_price();
    drive(0, 0, 1, 0, 0);
    n_cmp++;
    if (credit !== 6'd10) begin
      n_bad++;
      $display("FAIL exact_credit1: got %0d expected 10", credit);
    end
    drive(0, 0, 1, 0, 0);
    n_cmp++;
    if (credit !== 6'd20 || vend !== 1'b1 || change !== 6'd0) begin
      n_bad++;
      $display("FAIL exact_vend: got credit=%0d vend=%b change=%0d expected 20/1/0",
               credit, vend, change);
    end
    wait_vend("exact", 4);
    wait_dispense("exact", 1);
    n_cmp++;
    if (credit !== 6'd0) begin
      n_bad++;
      $display("FAIL exact_idle_credit: got %0d expected 0", credit);
    end
  endtask

  task automatic test_change();
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    repeat (4) drive(1, 0, 0, 0, 0);
    n_cmp++;
    if (credit !== 6'd19 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL change_credit19: got credit=%0d busy=%b expected 19/0", credit, busy);
    end
    drive(0, 0, 1, 0, 0);
    push_ret(3'b010, 4);
    for (int k = 3; k >= 0; k--) push_ret(3'b001, k);
    n_cmp++;
    if (credit !== 6'd29 || change !== 6'd9 || vend !== 1'b1) begin
      n_bad++;
      $display("FAIL change_vend: got credit=%0d change=%0d vend=%b expected 29/9/1",
               credit, change, vend);
    end
    wait_vend("change", 4);
    wait_dispense("change", 5);
    n_cmp++;
    if (credit !== 6'd0 || change !== 6'd0) begin
      n_bad++;
      $display("FAIL change_idle: got credit=%0d change=%0d expected 0/0", credit, change);
    end
  endtask

  task automatic test_refund();
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    push_ret(3'b100, 5);
    push_ret(3'b010, 0);
    n_cmp++;
    if (change !== 6'd15 || credit !== 6'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL refund_enter: got change=%0d credit=%0d busy=%b expected 15/0/1",
               change, credit, busy);
    end
    wait_dispense("refund", 2);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (busy !== 1'b0 || change !== 6'd0 || credit !== 6'd0 || ret_p !== 1'b0) begin
      n_bad++;
      $display("FAIL refund_zero_cancel: got busy=%b change=%0d credit=%0d expected 0/0/0",
               busy, change, credit);
    end
  endtask

  task automatic test_reject();
    drive(1, 0, 1, 0, 0);
    n_cmp++;
    if (credit !== 6'd1 || coin_rej !== 1'b1) begin
      n_bad++;
      $display("FAIL reject_multi: got credit=%0d rej=%b expected 1/1", credit, coin_rej);
    end
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (coin_rej !== 1'b0) begin
      n_bad++;
      $display("FAIL reject_single_pulse: got rej=%b expected 0", coin_rej);
    end
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    n_cmp++;
    if (coin_rej !== 1'b1 || credit !== 6'd21 || vend !== 1'b1) begin
      n_bad++;
      $display("FAIL reject_busy: got rej=%b credit=%0d vend=%b expected 1/21/1",
               coin_rej, credit, vend);
    end
    push_ret(3'b001, 0);
    wait_vend("reject", 3);
    wait_dispense("reject", 1);
  endtask

  task automatic test_coin_and_cancel();
    drive(0, 1, 0, 1, 0);
    push_ret(3'b010, 0);
    n_cmp++;
    if (change !== 6'd5 || credit !== 6'd0 || busy !== 1'b1 || vend !== 1'b0) begin
      n_bad++;
      $display("FAIL coin_cancel_refund: got change=%0d credit=%0d busy=%b expected 5/0/1",
               change, credit, busy);
    end
    wait_dispense("coin_cancel", 1);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0);
    n_cmp++;
    if (vend !== 1'b1 || credit !== 6'd20 || change !== 6'd0) begin
      n_bad++;
      $display("FAIL vend_beats_cancel: got vend=%b credit=%0d change=%0d expected 1/20/0",
               vend, credit, change);
    end
    wait_vend("vend_cancel", 4);
    wait_dispense("vend_cancel", 1);
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (29) drive(0, 0, 0, 0, 1);
    n_cmp++;
    if (busy !== 1'b0 || credit !== 6'd6) begin
      n_bad++;
      $display("FAIL timeout_early: got busy=%b credit=%0d expected 0/6", busy, credit);
    end
    drive(0, 0, 0, 0, 1);
    push_ret(3'b010, 1);
    push_ret(3'b001, 0);
    n_cmp++;
    if (busy !== 1'b1 || change !== 6'd6 || credit !== 6'd0) begin
      n_bad++;
      $display("FAIL timeout_refund: got busy=%b change=%0d credit=%0d expected 1/6/0",
               busy, change, credit);
    end
    wait_dispense("timeout", 2);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (29) drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    repeat (29) drive(0, 0, 0, 0, 1);
    n_cmp++;
    if (busy !== 1'b0 || credit !== 6'd7) begin
      n_bad++;
      $display("FAIL timeout_coin_restart: got busy=%b credit=%0d expected 0/7", busy, credit);
    end
    drive(0, 0, 0, 0, 1);
    push_ret(3'b010, 2);
    push_ret(3'b001, 1);
    push_ret(3'b001, 0);
    wait_dispense("timeout2", 3);
  endtask
`else
  task automatic test_no_timeout();
    drive(0, 1, 0, 0, 0);
    repeat (40) drive(0, 0, 0, 0, 1);
    n_cmp++;
    if (busy !== 1'b0 || credit !== 6'd5) begin
      n_bad++;
      $display("FAIL no_timeout_hold: got busy=%b credit=%0d expected 0/5", busy, credit);
    end
    drive(0, 0, 0, 1, 0);
    push_ret(3'b010, 0);
    wait_dispense("no_timeout", 1);
  endtask
`endif

  initial begin
    p = 1'b0; n = 1'b0; d = 1'b0; s = 1'b0; sec_tick = 1'b0;
    test_reset();
    test_exact_price();
    test_change();
    test_refund();
    test_reject();
    test_coin_and_cancel();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
